uart_transmitter: RTL and testbench

- Serial 8N1 UART transmitter; the sending counterpart of uart_receiver used on the programming path.
- Returns status and readback bytes (ICCM load acknowledge, checksum, debug dump) to the host over a dedicated TX pin.
- Bit period is a runtime input, matching the receiver's CLKS_PER_BIT input.
- A one-byte holding register gives gap-free back-to-back frames.

---
 rtl/uart_tx_pkg.sv | 14 +
 rtl/uart_transmitter.sv | 141 ++++++++++++++
 tb/tb_uart_transmitter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_tx_pkg;

  localparam int DataBits = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free frames.
// Optional parity bit after DATA when UART_TX_PARITY_EN is defined (sense set by ParityOdd).
// States: IDLE idle/line high | START start bit | DATA 8 data bits | PARITY parity bit | STOP stop bit
module uart_transmitter
  import uart_tx_pkg::*;
#(
  parameter logic ParityOdd = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] clks_per_bit_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_byte_i,
  output logic        tx_ready_o,
  output logic        o_tx_serial,
  output logic        o_tx_active,
  output logic        o_tx_done
);

  tx_state_e           state_q, state_d;
  logic [15:0]         cpb_q, cpb_d, cpb_sat;
  logic [15:0]         clk_cnt_q, clk_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [DataBits-1:0] shifter_q, shifter_d;
  logic [DataBits-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                serial_q, serial_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                accept, bit_end, last_stop;

  assign tx_ready_o  = ~hold_full_q;
  assign accept      = tx_valid_i & tx_ready_o;
  assign cpb_sat     = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
  assign bit_end     = (clk_cnt_q == cpb_q - 16'd1);
  assign last_stop   = (state_q == STOP) && bit_end;
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cpb_q       <= '0;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shifter_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpb_q       <= cpb_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shifter_q   <= shifter_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpb_d       = cpb_q;
    bit_idx_d   = bit_idx_q;
    shifter_d   = shifter_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    clk_cnt_d   = (state_q != IDLE && !bit_end) ? clk_cnt_q + 16'd1 : 16'd0;
    if (accept && state_q != IDLE) begin
      hold_d      = tx_byte_i;
      hold_full_d = 1'b1;
    end
    case (state_q)
      IDLE: if (accept) begin
        state_d   = START;
        shifter_d = tx_byte_i;
        cpb_d     = cpb_sat;
      end
      START: if (bit_end) begin
        state_d   = DATA;
        bit_idx_d = '0;
      end
      DATA: if (bit_end) begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'(DataBits - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      // A pending byte (held or offered right now) chains straight into START.
      STOP: if (bit_end) begin
        if (hold_full_q) begin
          state_d     = START;
          shifter_d   = hold_q;
          hold_full_d = 1'b0;
          cpb_d       = cpb_sat;
        end else if (accept) begin
          state_d     = START;
          shifter_d   = tx_byte_i;
          hold_full_d = 1'b0;
          cpb_d       = cpb_sat;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shifter_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = (^shifter_d) ^ ParityOdd;
`endif
      default: serial_d = 1'b1;
    endcase
    active_d = (state_d != IDLE);
    done_d   = last_stop;
  end

`ifndef UART_TX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = ParityOdd;
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame-level reference model plus literal frame checks.
module tb_uart_transmitter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [15:0] clks_per_bit_i = 16'd4;
  logic        tx_valid_i = 1'b0;
  logic [7:0]  tx_byte_i = 8'h00;
  logic        tx_ready_o, o_tx_serial, o_tx_active, o_tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic PAR_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  uart_transmitter #(.ParityOdd(PAR_ODD)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clks_per_bit_i (clks_per_bit_i),
    .tx_valid_i     (tx_valid_i),
    .tx_byte_i      (tx_byte_i),
    .tx_ready_o     (tx_ready_o),
    .o_tx_serial    (o_tx_serial),
    .o_tx_active    (o_tx_active),
    .o_tx_done      (o_tx_done)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bits, each held m_cpb cycles, indexed by frame time m_t.
  logic        m_busy = 1'b0, m_hold_full = 1'b0, m_done = 1'b0;
  logic [7:0]  m_hold = 8'h00;
  logic [10:0] m_bits = '1;
  int          m_t = 0, m_cpb = 1;
  logic        m_acc, m_last;
  int          m_cpb_in;

  assign m_acc    = tx_valid_i && !m_hold_full;
  assign m_last   = m_busy && (m_t == NBits * m_cpb - 1);
  assign m_cpb_in = (clks_per_bit_i == 16'd0) ? 1 : int'(clks_per_bit_i);

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = (^b) ^ PAR_ODD;
`endif
    return f;
  endfunction

  function automatic logic exp_line();
    if (!m_busy) return 1'b1;
    return m_bits[m_t / m_cpb];
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy      <= 1'b0;
      m_hold_full <= 1'b0;
      m_done      <= 1'b0;
      m_t         <= 0;
    end else begin
      m_done <= m_last;
      if (!m_busy) begin
        if (m_acc) begin
          m_busy <= 1'b1;
          m_t    <= 0;
          m_cpb  <= m_cpb_in;
          m_bits <= frame_of(tx_byte_i);
        end
      end else if (m_last) begin
        m_t <= 0;
        if (m_hold_full) begin
          m_hold_full <= 1'b0;
          m_cpb       <= m_cpb_in;
          m_bits      <= frame_of(m_hold);
        end else if (m_acc) begin
          m_cpb  <= m_cpb_in;
          m_bits <= frame_of(tx_byte_i);
        end else begin
          m_busy <= 1'b0;
        end
      end else begin
        m_t <= m_t + 1;
        if (m_acc) begin
          m_hold      <= tx_byte_i;
          m_hold_full <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("model_line",   o_tx_serial, exp_line());
    check("model_active", o_tx_active, m_busy);
    check("model_done",   o_tx_done,   m_done);
    check("model_ready",  tx_ready_o,  !m_hold_full);
  end

  // Call at a negedge with the transmitter idle; checks every frame cycle against a literal frame.
  task automatic send_literal(input string tag, input logic [7:0] b, input logic [15:0] cpb,
                              input int cpb_eff, input logic [10:0] frame);
    tx_valid_i     = 1'b1;
    tx_byte_i      = b;
    clks_per_bit_i = cpb;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    for (int k = 0; k < NBits * cpb_eff; k++) begin
      check({tag, "_line"},   o_tx_serial, frame[k / cpb_eff]);
      check({tag, "_active"}, o_tx_active, 1'b1);
      check({tag, "_nodone"}, o_tx_done,   1'b0);
      @(negedge clk_i);
    end
    check({tag, "_done"},     o_tx_done,   1'b1);
    check({tag, "_inactive"}, o_tx_active, 1'b0);
    check({tag, "_idle"},     o_tx_serial, 1'b1);
    @(negedge clk_i);
    check({tag, "_done_once"}, o_tx_done, 1'b0);
  endtask

  task automatic rx_decode(input int cpb, output logic [7:0] b);
    int n = 0;
    b = '0;
    @(negedge clk_i);
    while (o_tx_serial && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check("rx_start_seen", (n < 100), 1'b1);
    repeat (cpb / 2) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk_i);
      b[i] = o_tx_serial;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_tx_active || !tx_ready_o) && n < 2000) begin
      n++;
      @(negedge clk_i);
    end
    check({tag, "_idle_reached"}, (n < 2000), 1'b1);
    @(negedge clk_i);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rxb;
    int         n;
    int         fl;

    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_line",   o_tx_serial, 1'b1);
    check("rst_active", o_tx_active, 1'b0);
    check("rst_done",   o_tx_done,   1'b0);
    check("rst_ready",  tx_ready_o,  1'b1);
    rst_ni = 1'b1;
    @(negedge clk_i);

`ifdef UART_TX_PARITY_EN
    send_literal("a5", 8'hA5, 16'd4, 4, 11'b10101001010);
`else
    send_literal("a5", 8'hA5, 16'd4, 4, 11'b11101001010);
`endif

    // Back-to-back with valid held: second byte lands in the holding register.
    fl = NBits * 4;
    tx_valid_i     = 1'b1;
    tx_byte_i      = 8'h00;
    clks_per_bit_i = 16'd4;
    @(negedge clk_i);
    tx_byte_i = 8'hFF;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    check("b2b_ready_low", tx_ready_o, 1'b0);
    repeat (fl - 2) @(negedge clk_i);
    check("b2b_ready_still_low", tx_ready_o, 1'b0);
    check("b2b_stop1", o_tx_serial, 1'b1);
    @(negedge clk_i);
    check("b2b_start2", o_tx_serial, 1'b0);
    check("b2b_active", o_tx_active, 1'b1);
    check("b2b_done1",  o_tx_done,   1'b1);
    check("b2b_ready",  tx_ready_o,  1'b1);
    repeat (4) @(negedge clk_i);
    check("b2b_ff_bit0", o_tx_serial, 1'b1);
    repeat (fl - 5) @(negedge clk_i);
    check("b2b_stop2", o_tx_serial, 1'b1);
    @(negedge clk_i);
    check("b2b_done2",     o_tx_done,   1'b1);
    check("b2b_inactive2", o_tx_active, 1'b0);
    @(negedge clk_i);

    // Reset during DATA bit 3 with a byte waiting in the holding register.
    tx_valid_i     = 1'b1;
    tx_byte_i      = 8'h3C;
    clks_per_bit_i = 16'd4;
    @(negedge clk_i);
    tx_byte_i = 8'h99;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    check("rstmid_held", tx_ready_o, 1'b0);
    repeat (16) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("rstmid_line",   o_tx_serial, 1'b1);
    check("rstmid_ready",  tx_ready_o,  1'b1);
    check("rstmid_active", o_tx_active, 1'b0);
    check("rstmid_done",   o_tx_done,   1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 50; k++) begin
      check("rstmid_no_done", o_tx_done, 1'b0);
      check("rstmid_quiet",   o_tx_serial, 1'b1);
      @(negedge clk_i);
    end
`ifdef UART_TX_PARITY_EN
    send_literal("after_rst", 8'hA5, 16'd4, 4, 11'b10101001010);
`else
    send_literal("after_rst", 8'hA5, 16'd4, 4, 11'b11101001010);
`endif

`ifdef UART_TX_PARITY_EN
    send_literal("par07", 8'h07, 16'd2, 2, 11'b11000001110);
    send_literal("par03", 8'h03, 16'd2, 2, 11'b10000000110);
    send_literal("cpb0",  8'h81, 16'd0, 1, 11'b10100000010);
`else
    send_literal("cpb0",  8'h81, 16'd0, 1, 11'b11100000010);
`endif

    fork
      begin
        tx_valid_i     = 1'b1;
        tx_byte_i      = 8'h81;
        clks_per_bit_i = 16'd16;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
      end
      rx_decode(16, rxb);
    join
    check("loop_byte", rxb, 8'h81);
    wait_idle("loop");

    // Long bit period; a mid-frame period change must not take effect.
    tx_valid_i     = 1'b1;
    tx_byte_i      = 8'h55;
    clks_per_bit_i = 16'd10417;
    @(negedge clk_i);
    tx_valid_i     = 1'b0;
    clks_per_bit_i = 16'd5;
    n = 0;
    while (o_tx_serial == 1'b0 && n < 20000) begin
      n++;
      @(negedge clk_i);
    end
    check("slow_start_len", n, 10417);
    n = 0;
    while (o_tx_serial == 1'b1 && n < 20000) begin
      n++;
      @(negedge clk_i);
    end
    check("slow_bit0_len", n, 10417);
    repeat (100) @(negedge clk_i);
    check("slow_bit1_low", o_tx_serial, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check("slow_rst_line", o_tx_serial, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int c = 0; c < 3000; c++) begin
      tx_valid_i     = ($urandom_range(0, 3) == 0);
      tx_byte_i      = 8'($urandom);
      clks_per_bit_i = 16'($urandom_range(0, 5));
      @(negedge clk_i);
    end
    tx_valid_i = 1'b0;
    wait_idle("random");
    check("final_line", o_tx_serial, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
